// File: rtl/mux_pkg.sv
// Shared definitions for the pipelined N-to-1 mux.
// Mode encodings and flattened-bus helpers.
package mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  function automatic int slice_lo(int idx, int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/mux_nto1_pipe_if.sv
// Handshake bundle between producers, the mux and its consumer.
// master drives the inputs; slave is the mux side.
interface mux_nto1_pipe_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int SELW = $clog2(N);

  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [N*WIDTH-1:0]   in_data;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output mode, sel, in_data, in_valid,
    output out_ready,
    input  in_ready, out_data, out_sel,
    input  out_valid
  );

  modport slave (
    input  mode, sel, in_data, in_valid,
    input  out_ready,
    output in_ready, out_data, out_sel,
    output out_valid
  );
endinterface

// File: rtl/mux_nto1_pipe_rr_arbiter.sv
// Rotating-priority encoder: first request at or after ptr wins.
// Purely combinational; the pointer lives in the parent.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  input  logic                 en_i,
  output logic                 gnt_valid_o,
  output logic [$clog2(N)-1:0] gnt_o
);
  localparam int SELW = $clog2(N);

  int idx;

  // Scan downward so the lowest offset from ptr is written last.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_o       = '0;
    idx         = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % N;
      if (en_i && req_i[idx[SELW-1:0]]) begin
        gnt_valid_o = 1'b1;
        gnt_o       = idx[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_nto1_pipe.sv
// Pipelined N-to-1 mux, explicit or round-robin select.
// Output register plus skid register keep full rate under stall.
module mux_nto1_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_nto1_pipe_if.slave   bus
);
  localparam int SELW = $clog2(N);
  localparam int NP   = 2 ** SELW;

  logic [WIDTH-1:0] din [N];

  for (genvar i = 0; i < N; i++) begin : g_slice
    assign din[i] = bus.in_data[slice_lo(i, WIDTH) +: WIDTH];
  end

  logic [SELW-1:0]  ptr_q, ptr_d;
  logic             out_v_q, out_v_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SELW-1:0]  skid_sel_q, skid_sel_d;

  logic             arb_gv;
  logic [SELW-1:0]  arb_g;
  logic [NP-1:0]    vpad;
  logic             sel_ok;
  logic             gv;
  logic [SELW-1:0]  g;
  logic             acc_en;
  logic             xfer;

  rr_arbiter #(.N(N)) u_arb (
    .req_i       (bus.in_valid),
    .ptr_i       (ptr_q),
    .en_i        (bus.mode == MODE_RR),
    .gnt_valid_o (arb_gv),
    .gnt_o       (arb_g)
  );

  // Pad valid to 2**SELW so an out-of-range sel never indexes past it.
  always_comb begin
    vpad         = '0;
    vpad[N-1:0]  = bus.in_valid;
    sel_ok       = (int'(bus.sel) < N) && vpad[bus.sel];
  end

  always_comb begin
    gv = 1'b0;
    g  = '0;
    unique case (bus.mode)
      MODE_SEL: begin
        gv = sel_ok;
        g  = bus.sel;
      end
      MODE_RR: begin
        gv = arb_gv;
        g  = arb_g;
      end
      default: ;
    endcase
  end

  assign acc_en       = !skid_v_q;
  assign xfer         = rst_n && acc_en && gv;
  assign bus.in_ready = xfer ? ({{(N-1){1'b0}}, 1'b1} << g) : '0;

  always_comb begin
    ptr_d       = ptr_q;
    out_v_d     = out_v_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    if (xfer) begin
      ptr_d = (int'(g) == N - 1) ? '0 : g + 1'b1;
    end
    if (!out_v_q || bus.out_ready) begin
      if (skid_v_q) begin
        out_v_d    = 1'b1;
        out_data_d = skid_data_q;
        out_sel_d  = skid_sel_q;
        skid_v_d   = 1'b0;
      end else begin
        out_v_d = xfer;
        if (xfer) begin
          out_data_d = din[g];
          out_sel_d  = g;
        end
      end
    end else if (xfer) begin
      skid_v_d    = 1'b1;
      skid_data_d = din[g];
      skid_sel_d  = g;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_v_q     <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      skid_v_q    <= 1'b0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_v_q     <= out_v_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
    end
  end

  assign bus.out_valid = out_v_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed bench for mux_nto1_pipe (N=4 main, N=3 out-of-range).
// Inputs change at negedge; outputs sampled at negedge.
module tb_mux_nto1_pipe;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mux_nto1_pipe_if #(.WIDTH(32), .N(4)) ifa ();
  mux_nto1_pipe_if #(.WIDTH(32), .N(3)) ifb ();

  mux_nto1_pipe #(.WIDTH(32), .N(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  mux_nto1_pipe #(.WIDTH(32), .N(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  task automatic set_a(input int i, input logic [31:0] v);
    ifa.in_data[i*32 +: 32] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    ifa.in_valid = '0;
    ifb.in_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    ifa.mode      = MODE_RR;
    ifa.in_valid  = 4'b1111;
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_a(i, 32'h100 + i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (ifa.in_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL rst_in_ready got=%b exp=0000", ifa.in_ready);
    end
    n_chk++;
    if (ifa.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_out_valid got=%b exp=0", ifa.out_valid);
    end
    n_chk++;
    if (ifa.out_data !== 32'h0 || ifa.out_sel !== 2'd0) begin
      n_err++;
      $display("FAIL rst_out got=%h/%0d exp=0/0",
               ifa.out_data, ifa.out_sel);
    end
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (ifa.in_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL rst_first_grant got=%b exp=0001", ifa.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    ifa.in_valid = '0;
    n_chk++;
    if (ifa.out_valid !== 1'b1 || ifa.out_sel !== 2'd0 ||
        ifa.out_data !== 32'h100) begin
      n_err++;
      $display("FAIL rst_first_out got=%b/%0d/%h exp=1/0/100",
               ifa.out_valid, ifa.out_sel, ifa.out_data);
    end
    @(posedge clk);
  endtask

  task automatic test_sel();
    @(negedge clk);
    ifa.mode      = MODE_SEL;
    ifa.sel       = 2'd2;
    set_a(2, 32'h5);
    ifa.in_valid  = 4'b0100;
    ifa.out_ready = 1'b1;
    #1;
    n_chk++;
    if (ifa.in_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL sel_in_ready got=%b exp=0100", ifa.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    ifa.in_valid = '0;
    n_chk++;
    if (ifa.out_valid !== 1'b1 || ifa.out_data !== 32'h5 ||
        ifa.out_sel !== 2'd2) begin
      n_err++;
      $display("FAIL sel_out got=%b/%h/%0d exp=1/5/2",
               ifa.out_valid, ifa.out_data, ifa.out_sel);
    end
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (ifa.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL sel_drain got=%b exp=0", ifa.out_valid);
    end
  endtask

  task automatic test_rr();
    logic [1:0] exp_w [4];
    exp_w = '{2'd0, 2'd3, 2'd0, 2'd3};
    do_reset();
    ifa.mode      = MODE_RR;
    ifa.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_a(i, 32'h100 + i);
    ifa.in_valid  = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (ifa.out_valid !== 1'b1 || ifa.out_sel !== 2'(k % 4) ||
          ifa.out_data !== 32'h100 + 32'(k % 4)) begin
        n_err++;
        $display("FAIL rr_all[%0d] got=%b/%0d/%h exp=1/%0d/%h", k,
                 ifa.out_valid, ifa.out_sel, ifa.out_data,
                 k % 4, 32'h100 + 32'(k % 4));
      end
    end
    ifa.in_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (ifa.out_valid !== 1'b1 || ifa.out_sel !== exp_w[k]) begin
        n_err++;
        $display("FAIL rr_wrap[%0d] got=%b/%0d exp=1/%0d", k,
                 ifa.out_valid, ifa.out_sel, exp_w[k]);
      end
    end
    ifa.in_valid = '0;
    @(posedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] vals [4];
    logic [31:0] got [$];
    int          p;
    logic        take;
    vals = '{32'hA, 32'hB, 32'hC, 32'hD};
    do_reset();
    ifa.mode      = MODE_SEL;
    ifa.sel       = 2'd1;
    ifa.out_ready = 1'b1;
    set_a(1, vals[0]);
    ifa.in_valid  = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    ifa.out_ready = 1'b0;
    set_a(1, vals[1]);
    #1;
    n_chk++;
    if (ifa.in_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL bp_skid_accept got=%b exp=0010", ifa.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    set_a(1, vals[2]);
    for (int k = 0; k < 2; k++) begin
      #1;
      n_chk++;
      if (ifa.in_ready !== 4'b0000 || ifa.out_valid !== 1'b1 ||
          ifa.out_data !== 32'hA) begin
        n_err++;
        $display("FAIL bp_stall[%0d] rdy=%b v=%b d=%h exp=0000/1/a",
                 k, ifa.in_ready, ifa.out_valid, ifa.out_data);
      end
      @(posedge clk);
      @(negedge clk);
    end
    ifa.out_ready = 1'b1;
    p = 2;
    #1;
    n_chk++;
    if (ifa.in_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL bp_recover_rdy got=%b exp=0000", ifa.in_ready);
    end
    for (int k = 0; k < 10; k++) begin
      if (ifa.out_valid) got.push_back(ifa.out_data);
      take = ifa.in_ready[1];
      @(posedge clk);
      @(negedge clk);
      if (take) p++;
      if (p < 4) set_a(1, vals[p]);
      else ifa.in_valid = '0;
      #1;
    end
    n_chk++;
    if (got.size() != 4) begin
      n_err++;
      $display("FAIL bp_count got=%0d exp=4", got.size());
    end
    for (int k = 0; k < 4; k++) begin
      if (k < got.size()) begin
        n_chk++;
        if (got[k] !== vals[k]) begin
          n_err++;
          $display("FAIL bp_order[%0d] got=%h exp=%h", k, got[k], vals[k]);
        end
      end
    end
  endtask

  task automatic test_oor();
    @(negedge clk);
    ifb.mode      = MODE_SEL;
    ifb.sel       = 2'd3;
    ifb.in_valid  = 3'b111;
    ifb.out_ready = 1'b1;
    #1;
    n_chk++;
    if (ifb.in_ready !== 3'b000) begin
      n_err++;
      $display("FAIL oor_in_ready got=%b exp=000", ifb.in_ready);
    end
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (ifb.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL oor_out_valid got=%b exp=0", ifb.out_valid);
      end
    end
    ifb.sel = 2'd2;
    #1;
    n_chk++;
    if (ifb.in_ready !== 3'b100) begin
      n_err++;
      $display("FAIL oor_top_sel got=%b exp=100", ifb.in_ready);
    end
    ifb.in_valid = '0;
    @(posedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    ifa.mode      = MODE_SEL;
    ifa.sel       = 2'd0;
    ifa.out_ready = 1'b0;
    set_a(0, 32'hDEAD0001);
    ifa.in_valid  = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    set_a(0, 32'hDEAD0002);
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (ifa.in_ready !== 4'b0000 || ifa.out_data !== 32'hDEAD0001) begin
      n_err++;
      $display("FAIL mid_full rdy=%b d=%h exp=0000/dead0001",
               ifa.in_ready, ifa.out_data);
    end
    rst_n        = 1'b0;
    ifa.in_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n         = 1'b1;
    ifa.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++;
      if (ifa.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL mid_stale[%0d] v=%b d=%h exp=0",
                 k, ifa.out_valid, ifa.out_data);
      end
      @(posedge clk);
      @(negedge clk);
    end
    ifa.mode     = MODE_RR;
    ifa.in_valid = 4'b1111;
    #1;
    n_chk++;
    if (ifa.in_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL mid_ptr got=%b exp=0001", ifa.in_ready);
    end
    @(negedge clk);
    ifa.in_valid = '0;
    @(posedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    ifa.mode      = MODE_SEL;
    ifa.sel       = '0;
    ifa.in_data   = '0;
    ifa.in_valid  = '0;
    ifa.out_ready = 1'b1;
    ifb.mode      = MODE_SEL;
    ifb.sel       = '0;
    ifb.in_data   = '0;
    ifb.in_valid  = '0;
    ifb.out_ready = 1'b1;
    test_reset();
    test_sel();
    test_rr();
    test_backpressure();
    test_oor();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mux_nto1_pipe.md
# mux_nto1_pipe

Parametrised, pipelined N-to-1 data multiplexer with a valid/ready handshake on every input and on the output. Input selection runs in one of two modes: explicit select, or round-robin among valid inputs. It is the successor of the registered 2:1 datapath mux and is used where several producers share one downstream consumer, for example write-back and forwarding sources. A 2-entry output buffer (output register plus skid register) sustains one transfer per cycle under backpressure without losing or duplicating data.

## Interface
- WIDTH, 32, data width in bits
- N, 4, number of inputs (N >= 2; need not be a power of 2)
- SELW, $clog2(N), select/index width (derived localparam, not overridable)

- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  synchronous, active-low reset
- mode  in  1  0 = explicit select (MODE_SEL), 1 = round-robin (MODE_RR)
- sel  in  SELW  selected input index, used in MODE_SEL only
- in_data  in  N*WIDTH  flattened inputs; input i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N  per-input valid
- in_ready  out  N  per-input ready; at most one bit set
- out_data  out  WIDTH  registered output data
- out_sel  out  SELW  index of the input that supplied out_data
- out_valid  out  1  output valid
- out_ready  in  1  downstream ready

## Operation
- Accept enable: `acc_en = !skid_valid`.
- Grant in MODE_SEL:
  - g = sel when sel < N and in_valid[sel] = 1.
  - Otherwise there is no grant.
- Grant in MODE_RR:
  - g = the first i with in_valid[i] = 1, scanning ptr, ptr+1, … modulo N.
  - There is no grant when in_valid = 0.
- Ready: `in_ready[i] = acc_en && grant_valid && (g == i)`. in_ready depends combinationally on in_valid, sel and mode.
- Transfer: in_valid[g] && in_ready[g]. The captured pair is {in_data slice g, g}.
- Round-robin pointer:
  - On each transfer, ptr <= (g == N-1) ? 0 : g+1, in both modes.
  - ptr does not change on cycles without a transfer.
- Output buffer, evaluated on each posedge:
  - Output register free (out_valid = 0, or out_ready = 1):
    - If skid_valid: skid moves into out, and skid_valid <= 0.
    - Otherwise, a transfer loads out; with no transfer, out_valid <= 0.
  - Output register stalled (out_valid = 1, out_ready = 0): a transfer loads skid, and skid_valid <= 1.
  - Skid is loaded only when skid_valid = 0, which acc_en guarantees.
- Ordering:
  - Data leaves in acceptance order.
  - There is no loss and no duplication.
  - out_data and out_sel stay stable while out_valid = 1 and out_ready = 0.
- Mode and sel:
  - Both are sampled every cycle.
  - A change affects only future grants. Buffered entries are unaffected and ptr is retained.
- Reset (rst_n = 0 at a posedge):
  - out_valid = 0, out_data = 0, out_sel = 0, skid_valid = 0, skid contents = 0, ptr = 0.
  - in_ready is forced to 0 while rst_n = 0.
  - Reset mid-operation discards buffered data. Nothing from before the reset is emitted afterwards.

## Timing
- Latency: 1 cycle from an accepted transfer to out_valid, when the output register is free.
- Throughput: 1 transfer per cycle while out_ready = 1.
- Backpressure: after out_ready drops, at most 1 further transfer is accepted (into skid). in_ready then falls to 0 on the cycle after skid fills.
- Recovery: the cycle out_ready returns, skid drains into out, and in_ready reasserts on the following cycle.
- Simultaneous pop from skid and new transfer in the same cycle: cannot occur, because acc_en = 0 while skid_valid = 1.
- sel >= N (non-power-of-2 N) in MODE_SEL: no grant and in_ready = 0. This is not an error.

## Structure
- Shared package `mux_pkg`:
  - MODE_SEL = 1'b0, MODE_RR = 1'b1.
  - A helper function for the flattened-bus slice index.
- Sub-module `rr_arbiter` (parameter N):
  - Inputs: req[N], ptr, en.
  - Outputs: grant_valid and grant index.
  - Combinational rotate-priority-encode; the pointer register stays in mux_nto1_pipe.
- Top level holds the grant mux, the ptr register, the output register and the skid register.

## Test plan
Benches use WIDTH = 32 and N = 4 unless noted.
- **Reset:** rst_n = 0 for 2 cycles with in_valid = 4'b1111 → in_ready = 0, out_valid = 0, out_data = 0, out_sel = 0; first grant after release comes from input 0 in MODE_RR.
- **Explicit select:** mode = 0, sel = 2, in_data[2] = 32'h5, in_valid = 4'b0100, out_ready = 1 → in_ready = 4'b0100 the same cycle; next cycle out_valid = 1, out_data = 5, out_sel = 2.
- **Round-robin fairness:** mode = 1, in_valid = 4'b1111, out_ready = 1 for 8 cycles → out_sel = 0,1,2,3,0,1,2,3 on consecutive cycles. With in_valid = 4'b1001 → out_sel = 0,3,0,3 (wrap).
- **Backpressure:** mode = 0, sel = 1, input 1 presents 0xA, 0xB, 0xC, 0xD back-to-back; out_ready = 0 from cycle 1 → 0xA held in out, 0xB in skid, in_ready[1] = 0. Set out_ready = 1 → out emits 0xA, 0xB, 0xC, 0xD in order, each exactly once.
- **Out-of-range select:** N = 3, mode = 0, sel = 3, in_valid = 3'b111 → in_ready = 0 and out_valid stays 0.
- **Reset mid-operation:** skid full with out_ready = 0; rst_n = 0 for 1 cycle, then out_ready = 1 → out_valid = 0 with no stale data emitted, and ptr = 0.
